// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises interrupts and synchronous exceptions at commit,
// issues CSR update strobes, redirects fetch through a valid/ready handshake and tracks M/U privilege.
//
// state    | meaning
// BOOT     | offering RESET_PC to fetch after reset
// RUN      | sampling commits for traps and mret
// TAKE     | one-cycle trap entry strobes (mepc/mcause/mtval, MIE push)
// RET      | one-cycle mret strobes (MIE pop, privilege restore)
// WAIT_ACK | redirect offered, waiting for fetch to accept
module trap_ctrl #(
    parameter int                XLEN     = 64,
    parameter int                NUM_IRQ  = 16,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_valid,
    input  logic [XLEN-1:0]      commit_pc,
    input  logic [XLEN-1:0]      commit_npc,
    input  logic [31:0]          commit_instr,
    input  logic [6:0]           exc_i,
    input  logic [XLEN-1:0]      exc_addr,
    input  logic [NUM_IRQ-1:0]   irq_pending_i,
    input  logic [NUM_IRQ-1:0]   irq_enable_i,
    input  logic                 mstatus_mie_i,
    input  logic [1:0]           mstatus_mpp_i,
    input  logic [XLEN-1:0]      mtvec_i,
    input  logic [XLEN-1:0]      mepc_i,
    input  logic                 redirect_ready,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 set_epc_o,
    output logic [XLEN-1:0]      epc_o,
    output logic                 set_cause_o,
    output logic [XLEN-1:0]      cause_o,
    output logic                 set_mtval_o,
    output logic [XLEN-1:0]      mtval_o,
    output logic                 mie_push_o,
    output logic                 mie_pop_o,
    output logic [1:0]           priv_o
);

    localparam int CW = 5;
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_TAKE,
        S_RET,
        S_WAIT_ACK
    } state_t;

    state_t          state_q, state_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [1:0]      priv_q, priv_d;
    logic [1:0]      mpp_q, mpp_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            mtval_en_q, mtval_en_d;

    logic [NUM_IRQ-1:0] irq_cand;
    logic               irq_hit;
    logic [CW-1:0]      irq_code;

    logic            trap_hit;
    logic            ret_hit;
    logic            intr;
    logic [CW-1:0]   code;
    logic [XLEN-1:0] trap_mtval;
    logic            trap_mtval_en;
    logic [XLEN-1:0] handler_pc;

    // Fixed order 11, 3, 7 overrides the descending scan of the remaining lines.
    always_comb begin
        irq_cand = irq_pending_i & irq_enable_i;
        irq_hit  = 1'b0;
        irq_code = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_cand[i] && i != 3 && i != 7 && i != 11) begin
                irq_hit  = 1'b1;
                irq_code = CW'(i);
            end
        end
        if (irq_cand[7]) begin
            irq_hit  = 1'b1;
            irq_code = CW'(7);
        end
        if (irq_cand[3]) begin
            irq_hit  = 1'b1;
            irq_code = CW'(3);
        end
        if (irq_cand[11]) begin
            irq_hit  = 1'b1;
            irq_code = CW'(11);
        end
        irq_hit = irq_hit && ((priv_q == PRIV_U) || mstatus_mie_i);
    end

    always_comb begin
        trap_hit      = 1'b1;
        ret_hit       = 1'b0;
        intr          = 1'b0;
        code          = '0;
        trap_mtval    = '0;
        trap_mtval_en = 1'b0;
        if (irq_hit) begin
            intr = 1'b1;
            code = irq_code;
        end else if (exc_i[0]) begin
            code          = CW'(0);
            trap_mtval    = commit_pc;
            trap_mtval_en = 1'b1;
        end else if (exc_i[1] || (exc_i[2] && priv_q == PRIV_U)) begin
            code          = CW'(2);
            trap_mtval    = {{(XLEN-32){1'b0}}, commit_instr};
            trap_mtval_en = 1'b1;
        end else if (exc_i[4]) begin
            code          = CW'(3);
            trap_mtval    = commit_pc;
            trap_mtval_en = 1'b1;
        end else if (exc_i[5]) begin
            code          = CW'(6);
            trap_mtval    = exc_addr;
            trap_mtval_en = 1'b1;
        end else if (exc_i[6]) begin
            code          = CW'(4);
            trap_mtval    = exc_addr;
            trap_mtval_en = 1'b1;
        end else if (exc_i[3]) begin
            code = (priv_q == PRIV_U) ? CW'(8) : CW'(11);
        end else if (exc_i[2]) begin
            trap_hit = 1'b0;
            ret_hit  = 1'b1;
        end else begin
            trap_hit = 1'b0;
        end
        handler_pc = {mtvec_i[XLEN-1:2], 2'b00};
        if (intr && mtvec_i[1:0] == 2'b01) begin
            handler_pc = handler_pc + (XLEN'(code) << 2);
        end
    end

    always_comb begin
        state_d    = state_q;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        priv_d     = priv_q;
        mpp_d      = mpp_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        mtval_d    = mtval_q;
        mtval_en_d = mtval_en_q;
        case (state_q)
            S_BOOT: begin
                if (rv_q && redirect_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_RUN;
                end else begin
                    rv_d = 1'b1;
                end
            end
            S_RUN: begin
                if (commit_valid && trap_hit) begin
                    state_d    = S_TAKE;
                    rv_d       = 1'b1;
                    rpc_d      = handler_pc;
                    epc_d      = intr ? commit_npc : commit_pc;
                    cause_d    = {intr, {(XLEN-1-CW){1'b0}}, code};
                    mtval_d    = trap_mtval;
                    mtval_en_d = trap_mtval_en;
                end else if (commit_valid && ret_hit) begin
                    state_d = S_RET;
                    rv_d    = 1'b1;
                    rpc_d   = mepc_i;
                    mpp_d   = mstatus_mpp_i;
                end
            end
            S_TAKE, S_RET, S_WAIT_ACK: begin
                if (state_q == S_TAKE) priv_d = PRIV_M;
                if (state_q == S_RET)  priv_d = mpp_q;
                if (redirect_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            rv_q       <= 1'b0;
            rpc_q      <= RESET_PC;
            priv_q     <= PRIV_M;
            mpp_q      <= PRIV_M;
            epc_q      <= '0;
            cause_q    <= '0;
            mtval_q    <= '0;
            mtval_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            priv_q     <= priv_d;
            mpp_q      <= mpp_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            mtval_q    <= mtval_d;
            mtval_en_q <= mtval_en_d;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign busy_o         = (state_q != S_RUN);
    assign flush_o        = (state_q == S_TAKE) || (state_q == S_RET);
    assign set_epc_o      = (state_q == S_TAKE);
    assign set_cause_o    = (state_q == S_TAKE);
    assign set_mtval_o    = (state_q == S_TAKE) && mtval_en_q;
    assign mie_push_o     = (state_q == S_TAKE);
    assign mie_pop_o      = (state_q == S_RET);
    assign epc_o          = epc_q;
    assign cause_o        = cause_q;
    assign mtval_o        = mtval_q;
    assign priv_o         = priv_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a rule-level reference model queues the expected response of
// each commit and a negedge monitor pops and compares whenever the controller flushes.
module tb_trap_ctrl;

    localparam int          XLEN    = 64;
    localparam int          NUM_IRQ = 16;
    localparam logic [63:0] RST_PC  = 64'h8000_0000;

    logic              clk, rst;
    logic              commit_valid;
    logic [63:0]       commit_pc, commit_npc, exc_addr, mtvec_i, mepc_i;
    logic [31:0]       commit_instr;
    logic [6:0]        exc_i;
    logic [15:0]       irq_pending_i, irq_enable_i;
    logic              mstatus_mie_i;
    logic [1:0]        mstatus_mpp_i;
    logic              redirect_ready, redirect_valid;
    logic [63:0]       redirect_pc, epc_o, cause_o, mtval_o;
    logic              flush_o, busy_o, set_epc_o, set_cause_o, set_mtval_o;
    logic              mie_push_o, mie_pop_o;
    logic [1:0]        priv_o;

    trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_npc(commit_npc), .commit_instr(commit_instr), .exc_i(exc_i), .exc_addr(exc_addr),
        .irq_pending_i(irq_pending_i), .irq_enable_i(irq_enable_i), .mstatus_mie_i(mstatus_mie_i),
        .mstatus_mpp_i(mstatus_mpp_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_o(flush_o), .busy_o(busy_o), .set_epc_o(set_epc_o), .epc_o(epc_o),
        .set_cause_o(set_cause_o), .cause_o(cause_o), .set_mtval_o(set_mtval_o), .mtval_o(mtval_o),
        .mie_push_o(mie_push_o), .mie_pop_o(mie_pop_o), .priv_o(priv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc, npc;
        logic [31:0] instr;
        logic [6:0]  exc;
        logic [63:0] addr;
        logic [15:0] pend, en;
        logic        mie;
        logic [1:0]  mpp;
        logic [63:0] mtvec, mepc;
    } stim_t;

    typedef struct packed {
        logic        is_ret;
        logic [63:0] epc, cause, mtval;
        logic        mtval_en;
        logic [63:0] rpc;
        logic [1:0]  priv_after;
    } exp_t;

    exp_t      sb[$];
    int        irq_order[$];
    int        vectors = 0;
    int        errs    = 0;
    logic [1:0] model_priv = 2'b11;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: interrupt order list, then exception priority, straight from the trap rules.
    function automatic bit model(input stim_t s, input logic [1:0] priv, output exp_t e);
        bit hit  = 0;
        bit intr = 0;
        int code = 0;
        e = '0;
        if (priv == 2'b00 || s.mie) begin
            foreach (irq_order[k]) begin
                if (!hit && s.pend[irq_order[k]] && s.en[irq_order[k]]) begin
                    hit = 1; intr = 1; code = irq_order[k];
                end
            end
        end
        if (!hit) begin
            hit = 1;
            if (s.exc[0]) begin
                code = 0; e.mtval_en = 1; e.mtval = s.pc;
            end else if (s.exc[1] || (s.exc[2] && priv == 2'b00)) begin
                code = 2; e.mtval_en = 1; e.mtval = {32'd0, s.instr};
            end else if (s.exc[4]) begin
                code = 3; e.mtval_en = 1; e.mtval = s.pc;
            end else if (s.exc[5]) begin
                code = 6; e.mtval_en = 1; e.mtval = s.addr;
            end else if (s.exc[6]) begin
                code = 4; e.mtval_en = 1; e.mtval = s.addr;
            end else if (s.exc[3]) begin
                code = (priv == 2'b00) ? 8 : 11;
            end else if (s.exc[2]) begin
                e.is_ret = 1; e.rpc = s.mepc; e.priv_after = s.mpp;
                return 1;
            end else begin
                return 0;
            end
        end
        e.epc        = intr ? s.npc : s.pc;
        e.cause      = (intr ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(code);
        e.rpc        = (s.mtvec & ~64'd3) + ((intr && s.mtvec[1:0] == 2'b01) ? 64'(4 * code) : 64'd0);
        e.priv_after = 2'b11;
        return 1;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.pc    = {$urandom, $urandom};
        s.npc   = s.pc + 64'd4;
        s.instr = $urandom;
        s.exc   = 7'($urandom & $urandom);
        s.addr  = {$urandom, $urandom};
        s.pend  = ($urandom_range(0, 1) == 1) ? 16'($urandom & $urandom) : 16'd0;
        s.en    = 16'($urandom);
        s.mie   = 1'($urandom_range(0, 1));
        s.mpp   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        s.mtvec = {$urandom, $urandom};
        s.mepc  = {$urandom, $urandom};
        return s;
    endfunction

    function automatic stim_t base_stim();
        stim_t s = '0;
        s.mpp = 2'b11;
        return s;
    endfunction

    task automatic drive_stim(input stim_t s);
        commit_pc = s.pc; commit_npc = s.npc; commit_instr = s.instr; exc_i = s.exc;
        exc_addr = s.addr; irq_pending_i = s.pend; irq_enable_i = s.en;
        mstatus_mie_i = s.mie; mstatus_mpp_i = s.mpp; mtvec_i = s.mtvec; mepc_i = s.mepc;
    endtask

    task automatic noise();
        commit_pc = {$urandom, $urandom}; commit_npc = {$urandom, $urandom};
        commit_instr = $urandom; exc_addr = {$urandom, $urandom};
        mtvec_i = {$urandom, $urandom}; mepc_i = {$urandom, $urandom};
        irq_pending_i = 16'($urandom); exc_i = 7'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy_o) begin ok = 1; break; end
            redirect_ready = 1'($urandom_range(0, 1));
            noise();
            @(posedge clk); #1;
        end
        if (!ok) begin
            errs++;
            $display("FAIL idle_timeout: busy_o stuck at %0b required 0", busy_o);
        end
        redirect_ready = 1'b0;
    endtask

    task automatic issue(input stim_t s, input bit ready_now);
        exp_t e;
        chk("priv_before_commit", 64'(priv_o), 64'(model_priv));
        drive_stim(s);
        commit_valid   = 1'b1;
        redirect_ready = ready_now;
        if (model(s, model_priv, e)) begin
            sb.push_back(e);
            model_priv = e.priv_after;
        end
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    task automatic boot_seq();
        redirect_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                exc_i = 7'b0000010; commit_valid = 1'b1;
            end
            @(posedge clk); #1;
            commit_valid = 1'b0;
            chk("boot_valid", 64'(redirect_valid), 64'd1);
            chk("boot_pc", redirect_pc, RST_PC);
        end
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        chk("boot_busy_after_ack", 64'(busy_o), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_pc"}, redirect_pc, RST_PC);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        chk({tag, "_priv"}, 64'(priv_o), 64'd3);
        chk({tag, "_strobes"}, 64'({flush_o, set_epc_o, set_cause_o, set_mtval_o, mie_push_o, mie_pop_o}), 64'd0);
    endtask

    // Monitor: pops an expectation on every flush and checks the handshake rules every cycle.
    bit          prev_v = 0, prev_acc = 0, priv_pend = 0;
    logic [63:0] prev_pc = '0;
    logic [1:0]  priv_exp = 2'b11;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 0; prev_acc = 0; priv_pend = 0;
                continue;
            end
            if (flush_o) begin
                if (sb.size() == 0) begin
                    vectors++; errs++;
                    $display("FAIL unexpected_flush: got flush with cause %h, required no flush", cause_o);
                end else begin
                    e = sb.pop_front();
                    if (e.is_ret) begin
                        chk("ret_strobes", 64'({set_epc_o, set_cause_o, set_mtval_o, mie_push_o, mie_pop_o}), 64'b00001);
                    end else begin
                        chk("trap_strobes", 64'({set_epc_o, set_cause_o, mie_push_o, mie_pop_o}), 64'b1110);
                        chk("set_mtval", 64'(set_mtval_o), 64'(e.mtval_en));
                        chk("epc", epc_o, e.epc);
                        chk("cause", cause_o, e.cause);
                        if (e.mtval_en) chk("mtval", mtval_o, e.mtval);
                    end
                    chk("redirect_valid_rise", 64'(redirect_valid), 64'd1);
                    chk("redirect_pc", redirect_pc, e.rpc);
                    priv_pend = 1; priv_exp = e.priv_after;
                end
            end else begin
                chk("idle_strobes", 64'({set_epc_o, set_cause_o, set_mtval_o, mie_push_o, mie_pop_o}), 64'd0);
                if (priv_pend) begin
                    chk("priv_after", 64'(priv_o), 64'(priv_exp));
                    priv_pend = 0;
                end
            end
            if (prev_v && !prev_acc) begin
                chk("redirect_hold_valid", 64'(redirect_valid), 64'd1);
                chk("redirect_hold_pc", redirect_pc, prev_pc);
            end
            if (prev_acc) begin
                chk("ack_valid_drop", 64'(redirect_valid), 64'd0);
                chk("ack_to_run", 64'(busy_o), 64'd0);
            end
            if (redirect_valid) chk("busy_while_redirect", 64'(busy_o), 64'd1);
            prev_v   = redirect_valid;
            prev_acc = redirect_valid && redirect_ready;
            prev_pc  = redirect_pc;
        end
    end

    initial begin
        stim_t s;
        irq_order = '{11, 3, 7};
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (i != 3 && i != 7 && i != 11) irq_order.push_back(i);

        rst = 1'b0; commit_valid = 1'b0; redirect_ready = 1'b0;
        drive_stim(base_stim());
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b1;
        boot_seq();

        // mret in M to U
        s = base_stim(); s.exc = 7'b0000100; s.mepc = 64'h3000; s.mpp = 2'b00;
        issue(s, 1'b0); wait_idle();
        // illegal in U
        s = base_stim(); s.pc = 64'h1000; s.npc = 64'h1004; s.instr = 32'hFFFF_FFFF;
        s.exc = 7'b0000010; s.mtvec = 64'h4000;
        issue(s, 1'b1); wait_idle();
        // back to U, then mret in U is illegal
        s = base_stim(); s.exc = 7'b0000100; s.mepc = 64'h3000; s.mpp = 2'b00;
        issue(s, 1'b1); wait_idle();
        s = base_stim(); s.pc = 64'h3000; s.instr = 32'h3020_0073; s.exc = 7'b0000100; s.mtvec = 64'h5000;
        issue(s, 1'b0); wait_idle();
        // vectored interrupt priority
        s = base_stim(); s.pc = 64'h1000; s.npc = 64'h1004; s.mtvec = 64'h2001; s.mie = 1'b1;
        s.pend = 16'h0888; s.en = 16'h0888;
        issue(s, 1'b0); wait_idle();
        // masked interrupt plus ecall in M
        s = base_stim(); s.pc = 64'h1100; s.mtvec = 64'h2001; s.mie = 1'b0;
        s.pend = 16'h0080; s.en = 16'h0080; s.exc = 7'b0001000;
        issue(s, 1'b1); wait_idle();

        for (int n = 0; n < 300; n++) begin
            issue(rand_stim(), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        // reset while waiting for the redirect ack, with a commit during busy
        s = base_stim(); s.pc = 64'h7000; s.exc = 7'b0000010; s.mtvec = 64'h6000;
        issue(s, 1'b0);
        redirect_ready = 1'b0;
        @(posedge clk); #1;
        commit_valid = 1'b1; exc_i = 7'b0000001;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        chk("wait_ack_pc", redirect_pc, 64'h6000);
        rst = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        model_priv = 2'b11;
        @(posedge clk); #1;
        rst = 1'b1;
        boot_seq();
        s = base_stim(); s.pc = 64'h8800; s.exc = 7'b0010000; s.mtvec = 64'h9000;
        issue(s, 1'b1); wait_idle();

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised machine-mode trap controller for the multi-cycle core; it sits beside the stage sequencer and samples each instruction at writeback commit. It prioritises NUM_IRQ local interrupt lines and seven synchronous exception flags, then drives one-cycle CSR update strobes (mepc, mcause, mtval, mstatus.MIE push/pop). It redirects the fetch unit through a valid/ready handshake and tracks the current privilege level (M/U). New relative to the previous controller: generic IRQ count, ecall cause by privilege, trap address in mtval, a boot redirect, and a back-pressured redirect.

## Interface
- XLEN, 64, datapath/CSR width.
- NUM_IRQ, 16, local interrupt lines (legal 12..32); line i maps to mcause code i.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- commit_valid  in  1  one-cycle pulse: instruction finished writeback.
- commit_pc  in  XLEN  PC of committing instruction.
- commit_npc  in  XLEN  architectural next PC of that instruction.
- commit_instr  in  32  instruction word.
- exc_i  in  7  {misaligned_load, misaligned_store, ebreak, ecall, mret, illegal_inst, misaligned_inst}.
- exc_addr  in  XLEN  faulting data address for misaligned load/store.
- irq_pending_i  in  NUM_IRQ  mip bits (level).
- irq_enable_i  in  NUM_IRQ  mie bits.
- mstatus_mie_i  in  1  global M interrupt enable.
- mstatus_mpp_i  in  2  privilege to restore on mret.
- mtvec_i  in  XLEN  trap vector; [1:0] mode, 01 = vectored.
- mepc_i  in  XLEN  return address for mret.
- redirect_ready  in  1  fetch unit accepts redirect.
- redirect_valid  out  1  new PC offered to fetch.
- redirect_pc  out  XLEN  new PC.
- flush_o  out  1  one-cycle pulse: discard in-flight work.
- busy_o  out  1  sequencer must hold in fetch while high.
- set_epc_o / epc_o  out  1 / XLEN  mepc write strobe and value.
- set_cause_o / cause_o  out  1 / XLEN  mcause strobe; value {intr, 0…, code}.
- set_mtval_o / mtval_o  out  1 / XLEN  mtval strobe and value.
- mie_push_o  out  1  MPIE←MIE, MIE←0, MPP←priv.
- mie_pop_o  out  1  MIE←MPIE.
- priv_o  out  2  current privilege (3 = M, 0 = U).

## Operation
- States: BOOT, RUN, TAKE, RET, WAIT_ACK.
- BOOT: redirect_valid=1, redirect_pc=RESET_PC; on redirect_ready → RUN.
- RUN: evaluated only when commit_valid=1. Interrupt candidate = irq_pending_i & irq_enable_i, globally enabled if priv_o==U or mstatus_mie_i.
- Priority, first match wins: interrupt (order 11, 3, 7, then remaining lines descending index) > misaligned_inst > illegal_inst (includes mret while priv_o==U) > ebreak > misaligned_store > misaligned_load > ecall > mret. No match → stay RUN.
- Trap → TAKE. Strobe values:
  - epc: commit_npc for interrupts, commit_pc for exceptions.
  - cause codes: interrupt {1, i}; exceptions 0, 2, 3, 6, 4; ecall 8 from U, 11 from M.
  - mtval: misaligned_inst/ebreak→commit_pc; illegal→zero-extended commit_instr; misaligned load/store→exc_addr; others 0 with set_mtval_o=0.
- Handler PC: mtvec_i & ~3, plus 4·code when vectored and interrupt. Arithmetic modulo 2^XLEN.
- TAKE, one cycle: set_epc_o, set_cause_o, mie_push_o, flush_o, plus set_mtval_o where applicable. priv_o←3. Then → WAIT_ACK.
- mret in M → RET, one cycle: mie_pop_o=1, flush_o=1, redirect_pc=mepc_i, priv_o←mstatus_mpp_i. Then → WAIT_ACK.
- WAIT_ACK: hold redirect_valid and redirect_pc stable until redirect_ready; → RUN on the cycle it is sampled high.

## Timing
- Reset (rst=0, async): state BOOT, redirect_valid=0, redirect_pc=RESET_PC, priv_o=3, all strobes/flush 0, busy_o=1. The first edge after release drives redirect_valid=1.
- Decision registered: strobes and redirect_valid appear the cycle after the commit_valid pulse.
- redirect_valid rises in TAKE/RET and stays high through WAIT_ACK.
- Minimum trap latency: 1 cycle when redirect_ready is already high during TAKE. The handshake completes in TAKE only if ready is high; otherwise it completes in WAIT_ACK.
- busy_o is high in every state except RUN.
- commit_valid while busy_o=1: ignored.
- Input changes while busy_o=1 do not alter latched epc/cause/mtval/redirect_pc.
- rst asserted mid-trap: immediate return to reset values; pending redirect is dropped.

## Test plan
- Boot: release reset, hold ready low 3 cycles → redirect_valid=1, pc 0x8000_0000 held; ready=1 → RUN, busy_o=0 next cycle.
- Illegal in U: priv=0, commit_pc=0x1000, instr=0xFFFF_FFFF, illegal → cause=2, epc=0x1000, mtval=0xFFFF_FFFF, push pulse, redirect to mtvec base, priv_o=3.
- Vectored interrupt priority: mtvec=0x2001, lines 3, 7, 11 pending and enabled, MIE=1, npc=0x1004 → cause MSB=1 code 11, epc=0x1004, redirect 0x202C.
- Masked interrupt + ecall in M: MIE=0, line 7 pending, ecall → cause=11, interrupt not taken.
- mret: priv=3, mepc=0x3000, mpp=0 → pop pulse, flush, redirect 0x3000, priv_o=0. mret again in U → cause=2.
- Reset mid-WAIT_ACK and commit_valid during busy: no strobes, redirect_pc reloads RESET_PC.
